sprite_plotter: RTL and testbench
=================================

# sprite_plotter

Parametrised sprite rasteriser. It walks an SPR_W × SPR_H sprite frame held in an external synchronous ROM and emits one VGA-adapter pixel write per cycle at a latched screen origin. It supports multiple animation frames, transparent-colour skipping, an erase mode and screen-edge clipping. It sits between the game-state FSM, which issues start and waits for done, and the VGA adapter write port.

## Interface
Parameters:
- SPR_W, 22, sprite width in pixels.
- SPR_H, 17, sprite height in pixels.
- NUM_FRAMES, 2, frames stored back-to-back in ROM; frame f occupies addresses f·SPR_W·SPR_H upward.
- CW, 3, colour width.
- X_W, 9, screen x width.
- Y_W, 8, screen y width.
- SCREEN_W, 320, pixels with x ≥ SCREEN_W are suppressed.
- SCREEN_H, 240, pixels with y ≥ SCREEN_H are suppressed.
- TRANSPARENT, 0, colour key; not plotted in draw mode.
- BG_COLOUR, 0, colour written in erase mode.
- AW, clog2(NUM_FRAMES·SPR_W·SPR_H), ROM address width.
- FW, max(1, clog2(NUM_FRAMES)), frame index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- erase  in  1  mode, latched with start.
- frame  in  FW  frame index, latched with start. Values ≥ NUM_FRAMES are clamped to NUM_FRAMES−1.
- x_pos  in  X_W  origin x, latched with start.
- y_pos  in  Y_W  origin y, latched with start.
- rom_addr  out  AW  ROM address.
- rom_q  in  CW  ROM data; valid one cycle after rom_addr.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  CW  pixel colour.
- plot  out  1  write enable to the VGA adapter.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: start=1 latches the inputs and moves to RUN.
  - RUN: advance the pixel index k from 0 to N−1, where N = SPR_W·SPR_H. The state moves to DRAIN after issuing k = N−1.
  - DRAIN: one cycle that emits the final pixel, then moves to DONE.
  - DONE: done=1 for one cycle, then returns to IDLE.
- Raster order is row-major: col = k mod SPR_W, row = k div SPR_W, tracked with column and row counters. No divider.
- rom_addr = frame·N + k while in RUN. It holds its last value otherwise.
- Pixel pipeline is one stage. The registered outputs for pixel k appear the cycle after address k is issued:
  - x = x0 + col, truncated to X_W bits.
  - y = y0 + row, truncated to Y_W bits.
  - colour = erase ? BG_COLOUR : rom_q.
- plot=1 only when all of the following hold:
  - the pixel is valid;
  - (erase or rom_q ≠ TRANSPARENT);
  - x0+col < SCREEN_W and y0+row < SCREEN_H, compared at full (unwrapped) width, so wrapped coordinates are suppressed.
- When plot=0, x, y and colour still update; downstream ignores them.
- start in RUN, DRAIN or DONE is ignored and is not queued.
- Changes to erase, frame, x_pos or y_pos after latching have no effect.

## Timing
- Reset values: rom_addr=0, x=0, y=0, colour=0, plot=0, busy=0, done=0, state=IDLE.
- Reset in any state aborts the operation the same cycle. In-flight pixels are dropped and no done is produced.
- With start accepted at edge T0:
  - busy is high for cycles T0+1 … T0+N.
  - Pixel k is on the outputs in cycle T0+2+k, for k = 0 … N−1.
  - done is high in cycle T0+N+2.
  - The earliest next start is accepted at edge T0+N+3.
- Throughput is one pixel per cycle. There are no stalls.

## Test plan
1. Default parameters, ROM filled with 3'b100, start with x_pos=10, y_pos=20, frame=0. Required: 374 consecutive plot pulses. First pixel is (10,20) at T0+2, last is (31,36) at T0+375, done at T0+376, rom_addr runs 0…373.
2. Same as test 1, but ROM address 5 holds 0. Required: plot=0 only at cycle T0+7, coordinates (15,20) there; 373 pulses in total.
3. Same as test 2 with erase=1. Required: 374 pulses, all with colour=0, including the pixel at (15,20).
4. frame=1. Required: rom_addr runs 374…747. Then frame=3 (out of range): clamped to frame 1.
5. x_pos=310, y_pos=230. Required: only columns 0–9 and rows 0–9 are plotted, giving 100 pulses; done timing unchanged.
6. Assert start at T0+50 (during busy): ignored, done still at T0+376. In a second run, pull resetn low at T0+100: all outputs 0 on the next edge, no done, and a fresh start then completes normally.

Source files
------------

// File: rtl/sprite_plotter_if.sv
// Command, ROM and VGA-write signals of the sprite plotter, grouped as one bundle.
// The slave side is the plotter; the master side is the game FSM, ROM and VGA adapter.
interface sprite_plotter_if #(
    parameter int CW  = 3,
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int AW  = 10,
    parameter int FW  = 1
);
    logic           start;
    logic           erase;
    logic [FW-1:0]  frame;
    logic [X_W-1:0] x_pos;
    logic [Y_W-1:0] y_pos;
    logic [AW-1:0]  rom_addr;
    logic [CW-1:0]  rom_q;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [CW-1:0]  colour;
    logic           plot;
    logic           busy;
    logic           done;

    modport slave (
        input  start, erase, frame, x_pos, y_pos, rom_q,
        output rom_addr, x, y, colour, plot, busy, done
    );

    modport master (
        output start, erase, frame, x_pos, y_pos, rom_q,
        input  rom_addr, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Sprite rasteriser: walks one SPR_W x SPR_H frame of a synchronous ROM and emits
// one VGA-adapter pixel write per cycle, with colour keying, erase and screen clipping.
module sprite_plotter #(
    parameter int SPR_W       = 22,
    parameter int SPR_H       = 17,
    parameter int NUM_FRAMES  = 2,
    parameter int CW          = 3,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int TRANSPARENT = 0,
    parameter int BG_COLOUR   = 0,
    parameter int AW          = $clog2(NUM_FRAMES * SPR_W * SPR_H),
    parameter int FW          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    sprite_plotter_if.slave bus
);
    localparam int N     = SPR_W * SPR_H;
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             erase_r;
    logic [X_W-1:0]   x0_r;
    logic [Y_W-1:0]   y0_r;
    logic [AW-1:0]    addr_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             inb_q;
    logic             pix_valid_q;

    logic             last_pix;
    logic [FW-1:0]    frame_c;
    logic [AW-1:0]    base_addr;
    logic [31:0]      x_full;
    logic [31:0]      y_full;
    logic             busy_c;
    logic             done_c;

    assign last_pix  = (col_q == COL_W'(SPR_W - 1)) && (row_q == ROW_W'(SPR_H - 1));
    assign frame_c   = (32'(bus.frame) >= 32'(NUM_FRAMES)) ? FW'(NUM_FRAMES - 1) : bus.frame;
    assign base_addr = AW'(32'(frame_c) * 32'(N));
    // Unwrapped coordinates so that origins near the wrap point clip instead of folding.
    assign x_full    = 32'(x0_r) + 32'(col_q);
    assign y_full    = 32'(y0_r) + 32'(row_q);

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN: begin
                busy_c = 1'b1;
                if (last_pix) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q       <= '0;
            row_q       <= '0;
            erase_r     <= 1'b0;
            x0_r        <= '0;
            y0_r        <= '0;
            addr_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            inb_q       <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        erase_r <= bus.erase;
                        x0_r    <= bus.x_pos;
                        y0_r    <= bus.y_pos;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= base_addr;
                    end
                end
                S_RUN: begin
                    pix_valid_q <= 1'b1;
                    x_q         <= x_full[X_W-1:0];
                    y_q         <= y_full[Y_W-1:0];
                    inb_q       <= (x_full < 32'(SCREEN_W)) && (y_full < 32'(SCREEN_H));
                    if (!last_pix) begin
                        addr_q <= addr_q + 1'b1;
                        if (col_q == COL_W'(SPR_W - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Colour and the key test use rom_q directly: the ROM register is the pixel stage.
    assign bus.colour   = !pix_valid_q ? '0 : (erase_r ? CW'(BG_COLOUR) : bus.rom_q);
    assign bus.plot     = pix_valid_q & inb_q & (erase_r | (bus.rom_q != CW'(TRANSPARENT)));
    assign bus.rom_addr = addr_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: table-driven runs with a pixel scoreboard,
// plus hand-written reset-abort sequence.
module tb_sprite_plotter;
    localparam int N  = 374;
    localparam int SW = 22;

    typedef struct {
        int x_pos;
        int y_pos;
        int frame;
        bit erase;
        int hole;
        bit pattern;
        bit mid_start;
        int exp_base;
        int exp_plots;
    } vec_t;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    pix_t sbq[$];
    vec_t vecs[8];
    logic [2:0] mem [0:1023];

    sprite_plotter_if #(.CW(3), .X_W(9), .Y_W(8), .AW(10), .FW(2)) bus ();

    sprite_plotter #(.FW(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) bus.rom_q <= mem[bus.rom_addr];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
        chk({tag, "_x"},        32'(bus.x),        0);
        chk({tag, "_y"},        32'(bus.y),        0);
        chk({tag, "_colour"},   32'(bus.colour),   0);
        chk({tag, "_plot"},     32'(bus.plot),     0);
        chk({tag, "_busy"},     32'(bus.busy),     0);
        chk({tag, "_done"},     32'(bus.done),     0);
    endtask

    task automatic fill_rom(input bit pattern, input int hole);
        for (int a = 0; a < 1024; a++) mem[a] = pattern ? 3'((a % 7) + 1) : 3'b100;
        if (hole >= 0) mem[hole] = 3'b000;
    endtask

    task automatic issue_start(input vec_t v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.erase = v.erase;
        bus.frame = 2'(v.frame);
        bus.x_pos = 9'(v.x_pos);
        bus.y_pos = 8'(v.y_pos);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        pix_t e;
        int   plots;
        int   xf;
        int   yf;
        logic [2:0] romv;
        plots = 0;
        fill_rom(v.pattern, v.hole);
        sbq.delete();
        for (int k = 0; k < N; k++) begin
            xf   = v.x_pos + (k % SW);
            yf   = v.y_pos + (k / SW);
            romv = mem[v.exp_base + k];
            e.x  = 9'(xf);
            e.y  = 8'(yf);
            e.c  = v.erase ? 3'b000 : romv;
            e.p  = (xf < 320) && (yf < 240) && (v.erase || romv != 3'b000);
            sbq.push_back(e);
        end
        issue_start(v);
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            if (c == 5) begin
                bus.x_pos = ~bus.x_pos;
                bus.y_pos = ~bus.y_pos;
                bus.frame = ~bus.frame;
                bus.erase = ~bus.erase;
            end
            if (v.mid_start && c == 50) bus.start = 1'b1;
            if (v.mid_start && c == 51) bus.start = 1'b0;
            chk("busy", 32'(bus.busy), 32'(c <= N));
            chk("done", 32'(bus.done), 32'(c == N + 2));
            if (c <= N) chk("rom_addr", 32'(bus.rom_addr), 32'(v.exp_base + c - 1));
            if (c >= 2 && c <= N + 1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("plot",   32'(bus.plot),   32'(e.p));
                chk("x",      32'(bus.x),      32'(e.x));
                chk("y",      32'(bus.y),      32'(e.y));
                chk("colour", 32'(bus.colour), 32'(e.c));
                if (bus.plot) plots++;
            end else begin
                chk("plot_idle", 32'(bus.plot), 0);
            end
        end
        chk("plot_count", 32'(plots), 32'(v.exp_plots));
        chk("sb_empty",   32'(sbq.size()), 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.erase  = 1'b0;
        bus.frame  = '0;
        bus.x_pos  = '0;
        bus.y_pos  = '0;
        fill_rom(1'b0, -1);

        //            x    y   f  er  hole pat mid base plots
        vecs[0] = '{ 10,  20, 0, 0, -1,  0,  0,   0, 374};
        vecs[1] = '{ 10,  20, 0, 0,  5,  0,  0,   0, 373};
        vecs[2] = '{ 10,  20, 0, 1,  5,  0,  0,   0, 374};
        vecs[3] = '{ 10,  20, 1, 0, -1,  1,  0, 374, 374};
        vecs[4] = '{ 10,  20, 3, 0, -1,  1,  0, 374, 374};
        vecs[5] = '{310, 230, 0, 0, -1,  0,  0,   0, 100};
        vecs[6] = '{ 10,  20, 0, 0, -1,  1,  1,   0, 374};
        vecs[7] = '{500, 250, 1, 0, -1,  1,  0, 374,   0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a run: abort immediately, never pulse done.
        fill_rom(1'b0, -1);
        issue_start(vecs[0]);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 100) begin
                chk("busy_before_abort", 32'(bus.busy), 1);
                chk("plot_before_abort", 32'(bus.plot), 1);
                resetn = 1'b0;
            end
        end
        @(negedge clk);
        chk_all_zero("abort");
        resetn = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.plot) begin
                chk("no_done_after_abort", 32'({bus.done, bus.busy, bus.plot}), 0);
                break;
            end
        end
        chk("quiet_after_abort", 32'({bus.done, bus.busy, bus.plot}), 0);

        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
